// File: rtl/uart_tx.sv
// UART transmitter. It sends one frame per accepted word: a start bit, DATA_BITS data bits
// LSB first, an optional parity bit, then STOP_BITS stop bits. Each bit lasts OVERSAMPLING
// divpulse_in ticks, the same ratio the receiver oversamples at.
//
// Ports:
//   sysclk_in      system clock, all logic on posedge
//   nrst_in        asynchronous active-low reset
//   divpulse_in    one-cycle baud tick, OVERSAMPLING ticks per bit period
//   tx_data_in     word to send
//   tx_valid_in    producer has a word on tx_data_in
//   tx_ready_out   block accepts a word this cycle (high only when idle)
//   tx_done_out    one-cycle pulse at the end of the last stop bit
//   tx_serial_out  serial line, idle high
module uart_tx #(
  parameter int unsigned OVERSAMPLING = 8,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 sysclk_in,
  input  logic                 nrst_in,
  input  logic                 divpulse_in,
  input  logic [DATA_BITS-1:0] tx_data_in,
  input  logic                 tx_valid_in,
  output logic                 tx_ready_out,
  output logic                 tx_done_out,
  output logic                 tx_serial_out
);

  localparam int unsigned CW = $clog2(OVERSAMPLING);
  localparam int unsigned BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] DivLast  = CW'(OVERSAMPLING - 1);
  localparam logic [BW-1:0] DataLast = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] StopLast = BW'(STOP_BITS - 1);
  localparam logic          OddPar   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                 state_q;
  logic [CW-1:0]          div_cnt_q;
  logic [BW-1:0]          bit_cnt_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   parity_q;
  logic                   bit_end;

  // The current bit period ends on its OVERSAMPLING-th tick.
  always_comb begin
    bit_end = divpulse_in && (div_cnt_q == DivLast);
  end

  always_ff @(posedge sysclk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q       <= StIdle;
      div_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      parity_q      <= 1'b0;
      tx_ready_out  <= 1'b1;
      tx_done_out   <= 1'b0;
      tx_serial_out <= 1'b1;
    end else begin
      tx_done_out <= 1'b0;

      // Ticks are only counted inside a frame; the accept edge itself is never counted.
      if (state_q != StIdle && divpulse_in) begin
        div_cnt_q <= bit_end ? '0 : div_cnt_q + CW'(1);
      end

      case (state_q)
        StIdle: begin
          tx_ready_out  <= 1'b1;
          tx_serial_out <= 1'b1;
          if (tx_valid_in) begin
            shift_q       <= tx_data_in;
            parity_q      <= (^tx_data_in) ^ OddPar;
            tx_ready_out  <= 1'b0;
            tx_serial_out <= 1'b0;
            div_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            state_q       <= StStart;
          end
        end

        StStart: begin
          if (bit_end) begin
            tx_serial_out <= shift_q[0];
            bit_cnt_q     <= '0;
            state_q       <= StData;
          end
        end

        StData: begin
          if (bit_end) begin
            if (bit_cnt_q == DataLast) begin
              bit_cnt_q <= '0;
              if (PARITY_EN != 0) begin
                tx_serial_out <= parity_q;
                state_q       <= StParity;
              end else begin
                tx_serial_out <= 1'b1;
                state_q       <= StStop;
              end
            end else begin
              // shift_q[0] is the bit on the line; the next one is shift_q[1].
              shift_q       <= shift_q >> 1;
              tx_serial_out <= shift_q[1];
              bit_cnt_q     <= bit_cnt_q + BW'(1);
            end
          end
        end

        StParity: begin
          if (bit_end) begin
            tx_serial_out <= 1'b1;
            bit_cnt_q     <= '0;
            state_q       <= StStop;
          end
        end

        StStop: begin
          if (bit_end) begin
            if (bit_cnt_q == StopLast) begin
              bit_cnt_q     <= '0;
              tx_serial_out <= 1'b1;
              tx_ready_out  <= 1'b1;
              tx_done_out   <= 1'b1;
              state_q       <= StIdle;
            end else begin
              bit_cnt_q <= bit_cnt_q + BW'(1);
            end
          end
        end

        default: begin
          state_q       <= StIdle;
          div_cnt_q     <= '0;
          bit_cnt_q     <= '0;
          tx_serial_out <= 1'b1;
          tx_ready_out  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx. Three instances share clock, reset and a divpulse every 4 clocks:
//   dut 0: 8N1, dut 1: 8E1, dut 2: 8O2.
// A frame-level model predicts line/ready/done every cycle from the divpulse count since
// accept; directed frames also pin the line at bit centres and the frame length to literals.
module tb_uart_tx;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic divpulse = 1'b0;

  logic       valid_a [3];
  logic [7:0] data_a  [3];
  logic       ready_a [3];
  logic       done_a  [3];
  logic       line_a  [3];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  uart_tx #(.OVERSAMPLING(8), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .sysclk_in(clk), .nrst_in(nrst), .divpulse_in(divpulse), .tx_data_in(data_a[0]),
    .tx_valid_in(valid_a[0]), .tx_ready_out(ready_a[0]), .tx_done_out(done_a[0]),
    .tx_serial_out(line_a[0])
  );

  uart_tx #(.OVERSAMPLING(8), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
    .sysclk_in(clk), .nrst_in(nrst), .divpulse_in(divpulse), .tx_data_in(data_a[1]),
    .tx_valid_in(valid_a[1]), .tx_ready_out(ready_a[1]), .tx_done_out(done_a[1]),
    .tx_serial_out(line_a[1])
  );

  uart_tx #(.OVERSAMPLING(8), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
    .sysclk_in(clk), .nrst_in(nrst), .divpulse_in(divpulse), .tx_data_in(data_a[2]),
    .tx_valid_in(valid_a[2]), .tx_ready_out(ready_a[2]), .tx_done_out(done_a[2]),
    .tx_serial_out(line_a[2])
  );

  // Baud tick: high for one clock out of every four.
  initial begin
    int c = 0;
    forever begin
      @(posedge clk);
      #1;
      c++;
      divpulse = (c % 4 == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  bit         m_busy   [3];
  int         m_pulses [3];
  logic [11:0] m_frame [3];
  logic       m_line   [3];
  logic       m_ready  [3];
  logic       m_done   [3];

  function automatic int nbits(input int i);
    return 10 + i;  // 8N1 = 10, 8E1 = 11, 8O2 = 12 bit periods
  endfunction

  // Bit b of the result is the line level during bit period b.
  function automatic logic [11:0] build(input int i, input logic [7:0] d);
    logic [11:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (i > 0) f[9] = (^d) ^ (i == 2);
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_busy[i]   = 1'b0;
      m_pulses[i] = 0;
      m_line[i]   = 1'b1;
      m_ready[i]  = 1'b1;
      m_done[i]   = 1'b0;
    end
  endtask

  always @(negedge nrst) model_reset();

  always @(posedge clk) begin
    if (!nrst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_done[i] = 1'b0;
        if (!m_busy[i]) begin
          if (valid_a[i]) begin
            m_busy[i]   = 1'b1;
            m_pulses[i] = 0;
            m_frame[i]  = build(i, data_a[i]);
            m_line[i]   = 1'b0;
            m_ready[i]  = 1'b0;
          end
        end else if (divpulse) begin
          m_pulses[i]++;
          if (m_pulses[i] / 8 == nbits(i)) begin
            m_busy[i]  = 1'b0;
            m_ready[i] = 1'b1;
            m_done[i]  = 1'b1;
            m_line[i]  = 1'b1;
          end else begin
            m_line[i] = m_frame[i][m_pulses[i] / 8];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("line%0d", i), 32'(line_a[i]), 32'(m_line[i]));
        chk($sformatf("ready%0d", i), 32'(ready_a[i]), 32'(m_ready[i]));
        chk($sformatf("done%0d", i), 32'(done_a[i]), 32'(m_done[i]));
      end
    end
  end

  // ---------------- directed helpers ----------------
  // Returns #1 after the accept edge.
  task automatic accept(input int i, input logic [7:0] d, input bit hold);
    bit ok = 1'b0;
    @(posedge clk);
    #1;
    data_a[i]  = d;
    valid_a[i] = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (ready_a[i]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) valid_a[i] = 1'b0;
  endtask

  // Negedge n is n-0.5 clocks after the accept edge; bit b is sampled at n = 16 + 32*b.
  task automatic collect(input int i, input int nb, output logic [11:0] got, output int done_at);
    got     = '0;
    done_at = -1;
    for (int n = 1; n <= 800; n++) begin
      @(negedge clk);
      if (n >= 16 && (n - 16) % 32 == 0 && (n - 16) / 32 < nb) got[(n - 16) / 32] = line_a[i];
      if (done_a[i]) begin
        done_at = n;
        break;
      end
    end
    if (done_at < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic frame(input int i, input logic [7:0] d, input logic [11:0] exp, input int lo,
                       input int hi, input string name);
    logic [11:0] got;
    int          dn;
    accept(i, d, 1'b0);
    collect(i, nbits(i), got, dn);
    chk({name, "_bits"}, 32'(got), 32'(exp));
    chk({name, "_len"}, 32'(dn >= lo && dn <= hi), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] got;
    int          dn;
    bit          seen;
    for (int i = 0; i < 3; i++) begin
      valid_a[i] = 1'b0;
      data_a[i]  = 8'h00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_line", 32'(line_a[0]), 32'd1);
    chk("rst_ready", 32'(ready_a[0]), 32'd1);
    chk("rst_done", 32'(done_a[0]), 32'd0);
    @(posedge clk);
    #1 nrst = 1'b1;
    cmp_en = 1'b1;

    // 80 divpulses at 4 clks each, first one 1..4 clks after accept.
    frame(0, 8'hA5, 12'h34A, 316, 321, "a5_8n1");
    frame(1, 8'hA5, 12'h54A, 348, 353, "a5_even");
    frame(2, 8'hA5, 12'hF4A, 380, 385, "a5_odd_2stop");
    frame(2, 8'h3C, 12'hE78, 380, 385, "3c_2stop");
    frame(2, 8'h00, 12'hE00, 380, 385, "00_2stop");

    // Back-to-back with valid held; tx_data_in churns during the first frame.
    accept(0, 8'h55, 1'b1);
    @(posedge clk);
    #1 data_a[0] = 8'hFF;
    repeat (40) @(posedge clk);
    #1 data_a[0] = 8'hAA;
    seen = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (done_a[0]) begin
        seen = 1'b1;
        break;
      end
    end
    chk("b2b_first_done", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    chk("b2b_start_line", 32'(line_a[0]), 32'd0);
    chk("b2b_start_ready", 32'(ready_a[0]), 32'd0);
    valid_a[0] = 1'b0;
    data_a[0]  = 8'h00;
    fork
      collect(0, 10, got, dn);
      begin
        repeat (100) @(posedge clk);
        #1;
        valid_a[0] = 1'b1;
        data_a[0]  = 8'h0F;
        @(negedge clk);
        chk("busy_ready", 32'(ready_a[0]), 32'd0);
        @(posedge clk);
        #1 valid_a[0] = 1'b0;
      end
    join
    chk("b2b_aa_bits", 32'(got), 32'h354);
    chk("b2b_aa_len", 32'(dn >= 316 && dn <= 321), 32'd1);

    // Reset during data bit 4 (bit period 5), which is low for 0xA5.
    accept(0, 8'hA5, 1'b0);
    repeat (176) @(negedge clk);
    chk("pre_rst_bit4", 32'(line_a[0]), 32'd0);
    @(posedge clk);
    #1 nrst = 1'b0;
    #1;
    chk("mid_rst_line", 32'(line_a[0]), 32'd1);
    chk("mid_rst_ready", 32'(ready_a[0]), 32'd1);
    chk("mid_rst_done", 32'(done_a[0]), 32'd0);
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    frame(0, 8'h81, 12'h302, 316, 321, "post_rst_81");

    // Idle with divpulse running.
    repeat (50) @(negedge clk);
    chk("idle_line1", 32'(line_a[1]), 32'd1);
    chk("idle_ready1", 32'(ready_a[1]), 32'd1);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter, the counterpart of the team's oversampling UART receiver. It serialises one parallel word per frame onto tx_serial_out as start bit, DATA_BITS data bits LSB first, an optional parity bit, and 1 or 2 stop bits. Bit timing comes from the shared baud generator's divpulse_in tick, using the same OVERSAMPLING ratio as the receiver. It sits between a host-side producer (FIFO or register interface) and the TX pin.

Parameters:
OVERSAMPLING, 8, divpulse_in ticks per bit period (>=2)
DATA_BITS, 8, data bits per frame (5..9)
PARITY_EN, 0, 1 = insert parity bit after data
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (only used when PARITY_EN=1)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
sysclk_in  input  1  system clock; all logic on posedge
nrst_in  input  1  reset, asynchronous, active-low
divpulse_in  input  1  one-sysclk-wide baud tick from baud generator, OVERSAMPLING per bit
tx_data_in  input  DATA_BITS  word to send
tx_valid_in  input  1  producer has a word on tx_data_in
tx_ready_out  output  1  block accepts a word this cycle
tx_done_out  output  1  one-cycle pulse at end of the last stop bit
tx_serial_out  output  1  serial line, idle high

Behaviour:
- Reset (async assert, sync release): tx_serial_out=1, tx_ready_out=1, tx_done_out=0, state IDLE, all counters 0. Asserting reset mid-frame aborts the frame immediately and drives the line high. No partial completion and no tx_done_out pulse.
- All outputs are registered.
- States:
  - IDLE: tx_ready_out=1, line high, divpulse_in ignored.
  - START: line low.
  - DATA: line = shift_reg[0].
  - PARITY: line = parity bit. Skipped when PARITY_EN=0.
  - STOP: line high for STOP_BITS bit periods.
- Handshake: a transfer occurs on a posedge where tx_valid_in && tx_ready_out. On that edge:
  - tx_data_in is latched into shift_reg, and the parity bit is computed from the latched value (XOR of all bits, inverted when PARITY_ODD=1).
  - tx_ready_out goes 0, tx_serial_out goes 0, state = START, divpulse counter = 0, bit counter = 0.
- tx_valid_in while tx_ready_out=0 is ignored. Changes on tx_data_in after acceptance do not affect the frame.
- Bit timing:
  - Each bit period ends on the OVERSAMPLING-th divpulse_in counted from that bit's start.
  - At that edge the divpulse counter resets to 0 and the next bit is driven.
  - The start bit begins at the accept edge; its first period may therefore be up to one divpulse gap longer than nominal, which the receiver tolerates.
  - The divpulse counter is $clog2(OVERSAMPLING) bits wide and increments only on cycles with divpulse_in=1.
- DATA: shift_reg shifts right one position per bit period. The bit counter runs 0..DATA_BITS-1, and the state moves to PARITY or STOP after bit DATA_BITS-1.
- STOP: the bit counter counts stop periods. At the end of the final stop period:
  - state = IDLE, tx_ready_out=1, tx_done_out=1 for exactly one cycle.
  - The line stays high.
- Back-to-back: a word offered with tx_valid_in held high is accepted on the edge after tx_ready_out rises, i.e. the cycle after tx_done_out. No idle bit periods are inserted.
- Frame length in divpulses = OVERSAMPLING * (1 + DATA_BITS + PARITY_EN + STOP_BITS), ±1 divpulse gap for start-bit alignment.
- divpulse_in asserted on the accept edge itself is not counted.
- Illegal/default state encoding returns to IDLE with the line high.

Test Plan:
- OVERSAMPLING=8, DATA_BITS=8, no parity, STOP_BITS=1, divpulse every 4 clks, send 0xA5 -> line sequence 0,1,0,1,0,0,1,0,1,1, each bit 8 divpulses (32 clks). tx_done_out pulses once ~320 clks after accept; a loopback into uart_rx yields rx_data_out=0xA5.
- PARITY_EN=1, send 0xA5 -> parity bit 0 with PARITY_ODD=0 and 1 with PARITY_ODD=1, placed between data bit 7 and stop. Frame is 11 bit periods.
- STOP_BITS=2, send 0x3C -> line high for 16 divpulses after the data before tx_done_out. Then send 0x00 -> all data bits low, stop high.
- Hold tx_valid_in=1 with 0x55 then 0xAA -> second start bit falls exactly one clk after the tx_done_out pulse, no idle gap. Toggling tx_data_in mid-frame has no effect on the line.
- Assert nrst_in low during data bit 4 -> tx_serial_out=1 in the same cycle, tx_ready_out=1, no tx_done_out. After release, a new 0x81 frame is sent correctly.
- tx_valid_in pulsed while busy -> ignored, tx_ready_out stays 0, frame unchanged. divpulse_in toggling while idle -> line stays high, no state change.
